restador_serial_n: RTL and testbench

Bit-serial N-bit subtractor, the inverse companion of the combinational ripple-carry adder in the processor datapath. It computes A_num − B_num − borrow_in over N clock cycles, one bit per cycle, using a single full-subtractor cell and a borrow flip-flop. A start/busy/done handshake lets the control unit use it for low-area subtraction where single-cycle latency is not needed.

---
 rtl/restador_serial_n.sv | 152 +++++++++++++++
 tb/tb_restador_serial_n.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/restador_serial_n.sv
// -----------------------------------------------------------------------------
// restador_serial_n
//
// Bit-serial N-bit subtractor. Computes A_num - B_num - borrow_in one bit per
// clock using a single full-subtractor cell and a borrow flip-flop. A start/
// busy/done handshake frames each operation.
//
// Handshake: start is sampled only while the block is idle or in its done
// cycle (busy=0). An accepted start at edge k raises busy from edge k to edge
// k+N; done is a single-cycle pulse after edge k+N, at which point result and
// borrow_out hold the new difference. start is ignored while busy=1.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous, active-high reset
//   start       operation request
//   A_num       minuend, captured on the accepted start edge
//   B_num       subtrahend, captured on the accepted start edge
//   borrow_in   incoming borrow, captured on the accepted start edge
//   busy        high while bits are being processed
//   done        one-cycle completion pulse
//   result      registered difference modulo 2^N
//   borrow_out  registered final borrow (A_num < B_num + borrow_in, unsigned)
// -----------------------------------------------------------------------------
module restador_serial_n #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A_num,
    input  logic [N-1:0] B_num,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         borrow_out
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_sr_q, a_sr_d;
    logic [N-1:0]  b_sr_q, b_sr_d;
    logic [N-1:0]  diff_sr_q, diff_sr_d;
    logic          borrow_q, borrow_d;
    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  result_q, result_d;
    logic          borrow_out_q, borrow_out_d;

    // Full-subtractor cell operating on the current LSBs
    logic          bit_a, bit_b, bit_c;
    logic          diff_bit;
    logic          borrow_nxt;
    logic [N-1:0]  diff_shift;

    always_comb begin
        bit_a      = a_sr_q[0];
        bit_b      = b_sr_q[0];
        bit_c      = borrow_q;
        diff_bit   = bit_a ^ bit_b ^ bit_c;
        borrow_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bit_c);
        // New difference bit enters at the MSB; after N shifts bit 0 sits at the LSB.
        diff_shift = (diff_sr_q >> 1) | (N'(diff_bit) << (N - 1));
    end

    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        diff_sr_d    = diff_sr_q;
        borrow_d     = borrow_q;
        count_d      = count_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        result_d     = result_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d    = A_num;
                    b_sr_d    = B_num;
                    borrow_d  = borrow_in;
                    diff_sr_d = '0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sr_d    = a_sr_q >> 1;
                b_sr_d    = b_sr_q >> 1;
                diff_sr_d = diff_shift;
                borrow_d  = borrow_nxt;
                count_d   = count_q + CW'(1);
                busy_d    = 1'b1;
                if (count_q == CW'(N - 1)) begin
                    // Last bit: publish the completed difference and final borrow.
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    result_d     = diff_shift;
                    borrow_out_d = borrow_nxt;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            diff_sr_q    <= '0;
            borrow_q     <= 1'b0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            diff_sr_q    <= diff_sr_d;
            borrow_q     <= borrow_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_restador_serial_n.sv
// -----------------------------------------------------------------------------
// tb_restador_serial_n
//
// Bench for restador_serial_n with one N=4 and one N=8 instance. Drivers issue
// operations and push the expected {borrow, difference} and the expected done
// cycle into queues; monitors pop and compare on every done pulse.
// -----------------------------------------------------------------------------
module tb_restador_serial_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // N=4 instance
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4;
    logic [3:0] res4;

    // N=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8;
    logic [7:0] res8;

    restador_serial_n #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A_num(a4), .B_num(b4),
        .borrow_in(bin4), .busy(busy4), .done(done4), .result(res4),
        .borrow_out(bout4)
    );

    restador_serial_n #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A_num(a8), .B_num(b8),
        .borrow_in(bin8), .busy(busy8), .done(done8), .result(res8),
        .borrow_out(bout8)
    );

    // Scoreboard
    logic [4:0] exp4_q[$];
    int         cyc4_q[$];
    logic [8:0] exp8_q[$];
    int         cyc8_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: unsigned difference modulo 2^n with borrow = (a < b + bin).
    function automatic logic [8:0] ref_sub(input int n, input int a, input int b, input int bin);
        int d;
        logic [8:0] r;
        d = a - b - bin;
        r = '0;
        r[7:0] = 8'(d & ((1 << n) - 1));
        r[8]   = (a < b + bin);
        return r;
    endfunction

    function automatic logic [4:0] ref4(input int a, input int b, input int bin);
        logic [8:0] r;
        r = ref_sub(4, a, b, bin);
        return {r[8], r[3:0]};
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (!rst && done4) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL n4_unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                logic [4:0] e;
                int ec;
                e  = exp4_q.pop_front();
                ec = cyc4_q.pop_front();
                chk("n4_result", 32'(res4), 32'(e[3:0]));
                chk("n4_borrow_out", 32'(bout4), 32'(e[4]));
                chk("n4_done_cycle", 32'(cyc), 32'(ec));
            end
        end
        if (!rst && done8) begin
            if (exp8_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL n8_unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                logic [8:0] e;
                int ec;
                e  = exp8_q.pop_front();
                ec = cyc8_q.pop_front();
                chk("n8_result", 32'(res8), 32'(e[7:0]));
                chk("n8_borrow_out", 32'(bout8), 32'(e[8]));
                chk("n8_done_cycle", 32'(cyc), 32'(ec));
            end
        end
    end

    // Drivers: wait for busy low, present start for one cycle. Return on the
    // negedge just after the accepting edge.
    task automatic op4(input int a, input int b, input int bin);
        int t;
        t = 0;
        @(negedge clk);
        while (busy4 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("n4_wait_busy_timeout", 32'(busy4), 32'd0);
        start4 = 1'b1;
        a4 = 4'(a);
        b4 = 4'(b);
        bin4 = 1'(bin);
        exp4_q.push_back(ref4(a, b, bin));
        cyc4_q.push_back(cyc + 1 + 4);
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic op8(input int a, input int b, input int bin);
        int t;
        t = 0;
        @(negedge clk);
        while (busy8 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("n8_wait_busy_timeout", 32'(busy8), 32'd0);
        start8 = 1'b1;
        a8 = 8'(a);
        b8 = 8'(b);
        bin8 = 1'(bin);
        exp8_q.push_back(ref_sub(8, a, b, bin));
        cyc8_q.push_back(cyc + 1 + 8);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((exp4_q.size() != 0 || exp8_q.size() != 0 || busy4 || busy8) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) chk("drain_timeout", 32'(exp4_q.size() + exp8_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_done4", 32'(done4), 32'd0);
        chk("rst_result4", 32'(res4), 32'd0);
        chk("rst_bout4", 32'(bout4), 32'd0);
        chk("rst_result8", 32'(res8), 32'd0);
        chk("rst_bout8", 32'(bout8), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 7 - 3: busy must be high for exactly N cycles
        op4(7, 3, 0);
        chk("busy_cycle0", 32'(busy4), 32'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("busy_run", 32'(busy4), 32'd1);
        end
        @(negedge clk);
        chk("busy_after_done", 32'(busy4), 32'd0);
        chk("done_pulse_high", 32'(done4), 32'd1);
        @(negedge clk);
        chk("done_pulse_low", 32'(done4), 32'd0);

        // Negative results
        op4(3, 7, 0);
        op4(0, 0, 1);
        drain(100);

        // start during RUN must be ignored
        op4(9, 2, 0);
        @(negedge clk);
        start4 = 1'b1;
        a4 = 4'd1;
        b4 = 4'd1;
        @(negedge clk);
        start4 = 1'b0;
        drain(100);

        // Reset in the middle of RUN: outputs clear, no done
        op4(5, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy4), 32'd0);
        chk("midrst_done", 32'(done4), 32'd0);
        chk("midrst_result", 32'(res4), 32'd0);
        chk("midrst_bout", 32'(bout4), 32'd0);
        void'(exp4_q.pop_back());
        void'(cyc4_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        op4(5, 1, 0);
        drain(100);

        // Back-to-back: start held high through DONE
        begin
            @(negedge clk);
            start4 = 1'b1;
            a4 = 4'd6;
            b4 = 4'd2;
            bin4 = 1'b0;
            exp4_q.push_back(ref4(6, 2, 0));
            cyc4_q.push_back(cyc + 1 + 4);
            @(negedge clk);
            a4 = 4'd15;
            b4 = 4'd15;
            repeat (4) @(negedge clk);
            // Now in DONE; the next edge accepts the second operation.
            exp4_q.push_back(ref4(15, 15, 0));
            cyc4_q.push_back(cyc + 1 + 4);
            @(negedge clk);
            start4 = 1'b0;
        end
        drain(100);

        // N=8 directed
        op8(255, 1, 0);
        op8(0, 255, 1);
        drain(100);

        // Randomized, both widths interleaved
        for (int i = 0; i < 30; i++) begin
            op4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
            op8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(200);

        chk("n4_queue_empty", 32'(exp4_q.size()), 32'd0);
        chk("n8_queue_empty", 32'(exp8_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
